rename_unit: RTL and testbench

//  Single-wide register rename stage, directly upstream of ROB. Maps arch sources and dest to

---
 rtl/rename_unit_if.sv | 60 ++++++
 rtl/rename_unit.sv | 114 +++++++++++
 tb/tb_rename_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_unit_if.sv
// Rename-stage payload types and the rename <-> decode/ROB bus.
package rename_pkg;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned ARCH_W    = $clog2(ARCH_REGS);
    localparam int unsigned PHYS_W    = $clog2(PHYS_REGS);

    typedef logic [ARCH_W-1:0] arch_t;
    typedef logic [PHYS_W-1:0] phys_t;

    typedef struct packed {
        logic [15:0] payload;   // opaque opcode/immediate bits carried to dispatch
        logic        uses_rd;
        arch_t       rd_arch;
        logic        uses_rs1;
        arch_t       rs1_arch;
        logic        uses_rs2;
        arch_t       rs2_arch;
    } decoded_bundle_t;

    typedef struct packed {
        logic  uses_rd;
        arch_t rd_arch;
        phys_t pd_new;
        phys_t pd_old;
    } rob_entry_t;
endpackage

interface rename_if;
    logic                        dec_valid;
    logic                        dec_ready;
    rename_pkg::decoded_bundle_t dec_bundle;
    logic                        ren_valid;
    logic                        ren_ready;
    rename_pkg::decoded_bundle_t ren_bundle;
    rename_pkg::phys_t           ren_ps1;
    rename_pkg::phys_t           ren_ps2;
    rename_pkg::phys_t           ren_pd_new;
    rename_pkg::phys_t           ren_pd_old;
    logic                        commit_fire;
    rename_pkg::rob_entry_t      commit_entry;
    logic                        recover_valid;
    rename_pkg::rob_entry_t      recover_entry;
    logic                        flush_valid;
    logic [rename_pkg::PHYS_W:0] fl_count;

    modport slave (
        input  dec_valid, dec_bundle, ren_ready,
               commit_fire, commit_entry, recover_valid, recover_entry, flush_valid,
        output dec_ready, ren_valid, ren_bundle, ren_ps1, ren_ps2,
               ren_pd_new, ren_pd_old, fl_count
    );

    modport master (
        output dec_valid, dec_bundle, ren_ready,
               commit_fire, commit_entry, recover_valid, recover_entry, flush_valid,
        input  dec_ready, ren_valid, ren_bundle, ren_ps1, ren_ps2,
               ren_pd_new, ren_pd_old, fl_count
    );
endinterface

// File: rtl/rename_unit.sv
// Single-wide register rename: speculative/committed RATs plus circular free list.
module rename_unit #(
    parameter int unsigned ARCH_REGS = rename_pkg::ARCH_REGS,
    parameter int unsigned PHYS_REGS = rename_pkg::PHYS_REGS,
    parameter int unsigned PHYS_W_P  = rename_pkg::PHYS_W
) (
    input  logic    clk,
    input  logic    rst_n,
    rename_if.slave bus
);
    localparam int unsigned FL_D  = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FL_IW = $clog2(FL_D);
    localparam int unsigned FL_W  = FL_IW + 1;
    localparam int unsigned CNT_W = PHYS_W_P + 1;

    logic [PHYS_W_P-1:0] srat   [ARCH_REGS];
    logic [PHYS_W_P-1:0] crat   [ARCH_REGS];
    logic [PHYS_W_P-1:0] fl_mem [FL_D];
    logic [FL_W-1:0]     fl_head;
    logic [FL_W-1:0]     fl_tail;
    logic [FL_W-1:0]     fl_chead;

    logic [FL_W-1:0] fl_used_c;
    logic            dec_renames_c;
    logic            cmt_renames_c;
    logic            rec_renames_c;
    logic            gate_c;
    logic            alloc_c;
    logic            commit_c;
    logic            recover_c;
    logic            unused_c;

    // Event decode: which of alloc / commit / recover actually act this cycle.
    always_comb begin
        fl_used_c     = fl_tail - fl_head;
        dec_renames_c = bus.dec_bundle.uses_rd && (bus.dec_bundle.rd_arch != '0);
        cmt_renames_c = bus.commit_entry.uses_rd && (bus.commit_entry.rd_arch != '0);
        rec_renames_c = bus.recover_entry.uses_rd && (bus.recover_entry.rd_arch != '0);
        gate_c        = rst_n && !bus.recover_valid && !bus.flush_valid &&
                        (!dec_renames_c || (fl_used_c != '0));
        alloc_c       = bus.dec_valid && bus.ren_ready && gate_c && dec_renames_c;
        commit_c      = bus.commit_fire && cmt_renames_c && !bus.flush_valid;
        recover_c     = bus.recover_valid && rec_renames_c && !bus.flush_valid;
        unused_c      = ^bus.recover_entry.pd_new;
    end

    // Zero-latency lookup and handshake outputs; tags held at p0 while in reset.
    always_comb begin
        bus.ren_valid  = bus.dec_valid && gate_c;
        bus.dec_ready  = bus.ren_ready && gate_c;
        bus.ren_bundle = bus.dec_bundle;
        bus.fl_count   = CNT_W'(fl_used_c);
        bus.ren_ps1    = '0;
        bus.ren_ps2    = '0;
        bus.ren_pd_new = '0;
        bus.ren_pd_old = '0;
        if (rst_n) begin
            if (bus.dec_bundle.uses_rs1) bus.ren_ps1 = srat[bus.dec_bundle.rs1_arch];
            if (bus.dec_bundle.uses_rs2) bus.ren_ps2 = srat[bus.dec_bundle.rs2_arch];
            if (dec_renames_c) begin
                bus.ren_pd_new = fl_mem[fl_head[FL_IW-1:0]];
                bus.ren_pd_old = srat[bus.dec_bundle.rd_arch];
            end
        end
    end

    // Speculative RAT: flush restores committed map, recovery rewinds, rename allocates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) srat[i] <= PHYS_W_P'(i);
        end else if (bus.flush_valid) begin
            for (int i = 0; i < ARCH_REGS; i++) srat[i] <= crat[i];
        end else if (recover_c) begin
            srat[bus.recover_entry.rd_arch] <= bus.recover_entry.pd_old;
        end else if (alloc_c) begin
            srat[bus.dec_bundle.rd_arch] <= fl_mem[fl_head[FL_IW-1:0]];
        end
    end

    // Committed RAT follows retirement only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) crat[i] <= PHYS_W_P'(i);
        end else if (commit_c) begin
            crat[bus.commit_entry.rd_arch] <= bus.commit_entry.pd_new;
        end
    end

    // Free-list storage: retired pd_old is pushed at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FL_D; k++) fl_mem[k] <= PHYS_W_P'(ARCH_REGS + k);
        end else if (commit_c) begin
            fl_mem[fl_tail[FL_IW-1:0]] <= bus.commit_entry.pd_old;
        end
    end

    // Free-list pointers; the wrap bit distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_head  <= '0;
            fl_chead <= '0;
            fl_tail  <= FL_W'(FL_D);
        end else begin
            if (bus.flush_valid)  fl_head <= fl_chead;
            else if (recover_c)   fl_head <= fl_head - FL_W'(1);
            else if (alloc_c)     fl_head <= fl_head + FL_W'(1);
            if (commit_c) begin
                fl_tail  <= fl_tail + FL_W'(1);
                fl_chead <= fl_chead + FL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit with a queue-based reference model.
module tb_rename_unit;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rename_if bus();

    rename_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: maps plus free list as an ordered queue of tags,
    // and the tags handed out but not yet retired, oldest first.
    int m_srat [32];
    int m_crat [32];
    int m_free [$];
    int m_infl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_srat[i] = i;
            m_crat[i] = i;
        end
        m_free = {};
        m_infl = {};
        for (int k = 0; k < 32; k++) m_free.push_back(32 + k);
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        decoded_bundle_t d;
        rob_entry_t      ce;
        rob_entry_t      re;
        logic            ren;
        logic            ev;
        logic            ed;
        int              tag;
        if (!rst_n) begin
            model_reset();
            chk("rst_ren_valid", 64'(bus.ren_valid), 64'd0);
            chk("rst_dec_ready", 64'(bus.dec_ready), 64'd0);
            chk("rst_fl_count", 64'(bus.fl_count), 64'd32);
            chk("rst_pd_new", 64'(bus.ren_pd_new), 64'd0);
        end else begin
            d   = bus.dec_bundle;
            ce  = bus.commit_entry;
            re  = bus.recover_entry;
            ren = d.uses_rd && (d.rd_arch != 0);
            ev  = bus.dec_valid && !bus.recover_valid && !bus.flush_valid &&
                  (!ren || m_free.size() != 0);
            ed  = bus.ren_ready && !bus.recover_valid && !bus.flush_valid &&
                  (!ren || m_free.size() != 0);
            chk("m_ren_valid", 64'(bus.ren_valid), 64'(ev));
            chk("m_dec_ready", 64'(bus.dec_ready), 64'(ed));
            chk("m_fl_count", 64'(bus.fl_count), 64'(m_free.size()));
            if (ev) begin
                chk("m_ps1", 64'(bus.ren_ps1), 64'(d.uses_rs1 ? m_srat[d.rs1_arch] : 0));
                chk("m_ps2", 64'(bus.ren_ps2), 64'(d.uses_rs2 ? m_srat[d.rs2_arch] : 0));
                chk("m_pd_new", 64'(bus.ren_pd_new), 64'(ren ? m_free[0] : 0));
                chk("m_pd_old", 64'(bus.ren_pd_old), 64'(ren ? m_srat[d.rd_arch] : 0));
                chk("m_bundle", 64'(bus.ren_bundle), 64'(d));
            end
            if (bus.flush_valid) begin
                m_srat = m_crat;
                m_free = {m_infl, m_free};
                m_infl = {};
            end else begin
                if (bus.commit_fire && ce.uses_rd && ce.rd_arch != 0) begin
                    m_crat[ce.rd_arch] = int'(ce.pd_new);
                    m_free.push_back(int'(ce.pd_old));
                    if (m_infl.size() != 0) void'(m_infl.pop_front());
                end
                if (bus.recover_valid && re.uses_rd && re.rd_arch != 0) begin
                    m_srat[re.rd_arch] = int'(re.pd_old);
                    if (m_infl.size() != 0) m_free.push_front(m_infl.pop_back());
                end
                if (ev && bus.ren_ready && ren) begin
                    tag = m_free.pop_front();
                    m_srat[d.rd_arch] = tag;
                    m_infl.push_back(tag);
                end
            end
        end
    end

    task automatic dec(input int v, input int urd, input int rd,
                       input int u1, input int r1, input int u2, input int r2);
        decoded_bundle_t b;
        b          = '0;
        b.payload  = 16'($urandom);
        b.uses_rd  = 1'(urd);
        b.rd_arch  = ARCH_W'(rd);
        b.uses_rs1 = 1'(u1);
        b.rs1_arch = ARCH_W'(r1);
        b.uses_rs2 = 1'(u2);
        b.rs2_arch = ARCH_W'(r2);
        bus.dec_valid  = 1'(v);
        bus.dec_bundle = b;
    endtask

    function automatic rob_entry_t ent(input int rd, input int pn, input int po);
        rob_entry_t e;
        e.uses_rd = 1'b1;
        e.rd_arch = ARCH_W'(rd);
        e.pd_new  = PHYS_W'(pn);
        e.pd_old  = PHYS_W'(po);
        return e;
    endfunction

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0);
        bus.ren_ready     = 1'b1;
        bus.commit_fire   = 1'b0;
        bus.commit_entry  = '0;
        bus.recover_valid = 1'b0;
        bus.recover_entry = '0;
        bus.flush_valid   = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Rename x5, then read x5 back; backpressure; commit; flush.
        dec(1, 1, 5, 1, 5, 0, 0);
        @(negedge clk);
        chk("t1_pd_new", 64'(bus.ren_pd_new), 64'd32);
        chk("t1_pd_old", 64'(bus.ren_pd_old), 64'd5);
        chk("t1_cnt_before", 64'(bus.fl_count), 64'd32);
        nxt();
        dec(1, 0, 0, 1, 5, 0, 0);
        @(negedge clk);
        chk("t1_ps1_x5", 64'(bus.ren_ps1), 64'd32);
        chk("t1_cnt_after", 64'(bus.fl_count), 64'd31);
        nxt();
        bus.ren_ready = 1'b0;
        dec(1, 1, 6, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_valid", 64'(bus.ren_valid), 64'd1);
        chk("bp_ready", 64'(bus.dec_ready), 64'd0);
        nxt();
        bus.ren_ready = 1'b1;
        @(negedge clk);
        chk("bp_pd_new", 64'(bus.ren_pd_new), 64'd33);
        nxt();
        dec(0, 0, 0, 0, 0, 0, 0);
        bus.commit_fire  = 1'b1;
        bus.commit_entry = ent(5, 32, 5);
        nxt();
        bus.commit_fire = 1'b0;
        @(negedge clk);
        chk("t3_cnt_commit", 64'(bus.fl_count), 64'd31);
        nxt();
        bus.flush_valid = 1'b1;
        dec(1, 1, 7, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_flush_valid", 64'(bus.ren_valid), 64'd0);
        nxt();
        bus.flush_valid = 1'b0;
        dec(1, 1, 7, 1, 5, 1, 6);
        @(negedge clk);
        chk("t3_ps1_x5", 64'(bus.ren_ps1), 64'd32);
        chk("t3_ps2_x6", 64'(bus.ren_ps2), 64'd6);
        chk("t3_pd_new", 64'(bus.ren_pd_new), 64'd33);
        chk("t3_cnt", 64'(bus.fl_count), 64'd32);
        nxt();

        // Three renames then a youngest-first recovery walk.
        do_reset();
        dec(1, 1, 1, 0, 0, 0, 0);
        nxt();
        dec(1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_pd_old_x1", 64'(bus.ren_pd_old), 64'd32);
        nxt();
        dec(1, 1, 2, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_pd_new_x2", 64'(bus.ren_pd_new), 64'd34);
        nxt();
        dec(1, 1, 9, 0, 0, 0, 0);
        bus.recover_valid = 1'b1;
        bus.recover_entry = ent(2, 34, 2);
        @(negedge clk);
        chk("t4_rec_valid", 64'(bus.ren_valid), 64'd0);
        chk("t4_rec_ready", 64'(bus.dec_ready), 64'd0);
        nxt();
        bus.recover_entry = ent(1, 33, 32);
        nxt();
        bus.recover_entry = ent(1, 32, 1);
        nxt();
        bus.recover_valid = 1'b0;
        dec(1, 1, 3, 1, 1, 1, 2);
        @(negedge clk);
        chk("t4_ps1_x1", 64'(bus.ren_ps1), 64'd1);
        chk("t4_ps2_x2", 64'(bus.ren_ps2), 64'd2);
        chk("t4_pd_new", 64'(bus.ren_pd_new), 64'd32);
        chk("t4_cnt", 64'(bus.fl_count), 64'd32);
        nxt();

        // Drain the free list, then same-cycle commit with a stalled rename.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            dec(1, 1, (i % 31) + 1, 1, (i % 31) + 1, 1, ((i + 7) % 31) + 1);
            nxt();
        end
        dec(1, 1, 4, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_empty_valid", 64'(bus.ren_valid), 64'd0);
        chk("t2_empty_ready", 64'(bus.dec_ready), 64'd0);
        chk("t2_empty_cnt", 64'(bus.fl_count), 64'd0);
        nxt();
        dec(1, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("t2_store_valid", 64'(bus.ren_valid), 64'd1);
        chk("t2_store_ps1", 64'(bus.ren_ps1), 64'd63);
        nxt();
        dec(1, 1, 4, 0, 0, 0, 0);
        bus.commit_fire  = 1'b1;
        bus.commit_entry = ent(1, 32, 1);
        @(negedge clk);
        chk("t5_same_cycle_valid", 64'(bus.ren_valid), 64'd0);
        nxt();
        bus.commit_fire = 1'b0;
        @(negedge clk);
        chk("t5_cnt_one", 64'(bus.fl_count), 64'd1);
        chk("t5_pd_new", 64'(bus.ren_pd_new), 64'd1);
        nxt();
        dec(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cnt_end", 64'(bus.fl_count), 64'd0);
        nxt();

        // x0 destination, then reset asserted in the middle of recovery.
        do_reset();
        dec(1, 1, 3, 0, 0, 0, 0);
        nxt();
        dec(1, 1, 0, 1, 3, 0, 0);
        @(negedge clk);
        chk("t6_x0_valid", 64'(bus.ren_valid), 64'd1);
        chk("t6_x0_pd_new", 64'(bus.ren_pd_new), 64'd0);
        chk("t6_x0_pd_old", 64'(bus.ren_pd_old), 64'd0);
        chk("t6_x0_ps1", 64'(bus.ren_ps1), 64'd32);
        nxt();
        dec(1, 1, 4, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_x0_no_alloc", 64'(bus.fl_count), 64'd31);
        nxt();
        dec(0, 0, 0, 0, 0, 0, 0);
        bus.recover_valid = 1'b1;
        bus.recover_entry = ent(4, 33, 4);
        nxt();
        bus.recover_entry = ent(3, 32, 3);
        dec(1, 1, 5, 1, 3, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_cnt", 64'(bus.fl_count), 64'd32);
        chk("t6_rst_valid", 64'(bus.ren_valid), 64'd0);
        chk("t6_rst_ps1", 64'(bus.ren_ps1), 64'd0);
        nxt();
        rst_n = 1'b1;
        bus.recover_valid = 1'b0;
        dec(1, 1, 3, 1, 3, 1, 4);
        @(negedge clk);
        chk("t6_ps1_x3", 64'(bus.ren_ps1), 64'd3);
        chk("t6_ps2_x4", 64'(bus.ren_ps2), 64'd4);
        chk("t6_pd_new", 64'(bus.ren_pd_new), 64'd32);
        nxt();

        idle();
        repeat (3) nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
